// File: rtl/nv_nvdla_pdp_reg_multi_group.sv
// PDP single-register block for NUM_GROUPS ping-pong register groups: producer pointer,
// per-group op_enable flags, saturating done-event counter and a combinational CSB read path.
module nv_nvdla_pdp_reg_multi_group #(
  parameter int NUM_GROUPS = 4,
  parameter int CNT_W      = 16,
  localparam int PTR_W     = $clog2(NUM_GROUPS)
) (
  input  logic                    nvdla_core_clk,
  input  logic                    nvdla_core_rst,
  input  logic [11:0]             reg_offset,
  input  logic [31:0]             reg_wr_data,
  input  logic                    reg_wr_en,
  output logic [31:0]             reg_rd_data,
  input  logic [PTR_W-1:0]        consumer,
  input  logic [2*NUM_GROUPS-1:0] status,
  input  logic                    op_done,
  output logic [PTR_W-1:0]        producer,
  output logic [NUM_GROUPS-1:0]   op_en
);

  localparam logic [11:0] ADDR_STATUS  = 12'h000;
  localparam logic [11:0] ADDR_POINTER = 12'h004;
  localparam logic [11:0] ADDR_OP_EN   = 12'h008;
  localparam logic [11:0] ADDR_EN_ALL  = 12'h00C;
  localparam logic [11:0] ADDR_DONE    = 12'h010;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [PTR_W-1:0]      producer_reg, producer_next;
  logic [NUM_GROUPS-1:0] op_en_reg, op_en_next;
  logic [CNT_W-1:0]      done_cnt_reg, done_cnt_next;

  logic wr_pointer, wr_op_en, wr_done;

  assign wr_pointer = reg_wr_en && (reg_offset == ADDR_POINTER);
  assign wr_op_en   = reg_wr_en && (reg_offset == ADDR_OP_EN);
  assign wr_done    = reg_wr_en && (reg_offset == ADDR_DONE);

  // Upper write bits are dropped so the pointer wraps modulo NUM_GROUPS.
  always_comb begin
    producer_next = producer_reg;
    if (wr_pointer) begin
      producer_next = reg_wr_data[PTR_W-1:0];
    end
  end

  // Per-group flag: op_done clears, software set applied last so it wins on a collision.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_GROUPS; gi++) begin : g_op_en
      always_comb begin
        op_en_next[gi] = op_en_reg[gi];
        if (op_done && (consumer == PTR_W'(gi))) begin
          op_en_next[gi] = 1'b0;
        end
        if (wr_op_en && reg_wr_data[0] && (producer_reg == PTR_W'(gi))) begin
          op_en_next[gi] = 1'b1;
        end
      end
    end
  endgenerate

  // A clear coinciding with a done event leaves that event counted.
  always_comb begin
    done_cnt_next = done_cnt_reg;
    if (wr_done) begin
      done_cnt_next = op_done ? CNT_W'(1) : '0;
    end else if (op_done && (done_cnt_reg != CNT_MAX)) begin
      done_cnt_next = done_cnt_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      producer_reg <= '0;
      op_en_reg    <= '0;
      done_cnt_reg <= '0;
    end else begin
      producer_reg <= producer_next;
      op_en_reg    <= op_en_next;
      done_cnt_reg <= done_cnt_next;
    end
  end

  always_comb begin
    reg_rd_data = '0;
    case (reg_offset)
      ADDR_STATUS:  reg_rd_data[2*NUM_GROUPS-1:0] = status;
      ADDR_POINTER: begin
        reg_rd_data[PTR_W-1:0]     = producer_reg;
        reg_rd_data[16+PTR_W-1:16] = consumer;
      end
      ADDR_OP_EN:   reg_rd_data[0] = op_en_reg[producer_reg];
      ADDR_EN_ALL:  reg_rd_data[NUM_GROUPS-1:0] = op_en_reg;
      ADDR_DONE:    reg_rd_data[CNT_W-1:0] = done_cnt_reg;
      default:      reg_rd_data = '0;
    endcase
  end

  assign producer = producer_reg;
  assign op_en    = op_en_reg;

endmodule

// File: tb/tb_nv_nvdla_pdp_reg_multi_group.sv
// Scoreboard bench: stimulus pushes hand-computed expectations, a negedge monitor pops and compares.
// A second instance with CNT_W=2 shares every input to exercise counter saturation.
module tb_nv_nvdla_pdp_reg_multi_group;

  localparam int NG = 4;
  localparam int PW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [11:0]   reg_offset;
  logic [31:0]   reg_wr_data;
  logic          reg_wr_en;
  logic [PW-1:0] consumer;
  logic [2*NG-1:0] status;
  logic          op_done;
  logic [31:0]   rd_a, rd_b;
  logic [PW-1:0] producer_a, producer_b;
  logic [NG-1:0] op_en_a, op_en_b;

  always #5 clk = ~clk;

  nv_nvdla_pdp_reg_multi_group #(.NUM_GROUPS(NG), .CNT_W(16)) dut_a (
    .nvdla_core_clk(clk), .nvdla_core_rst(rst), .reg_offset(reg_offset),
    .reg_wr_data(reg_wr_data), .reg_wr_en(reg_wr_en), .reg_rd_data(rd_a),
    .consumer(consumer), .status(status), .op_done(op_done),
    .producer(producer_a), .op_en(op_en_a));

  nv_nvdla_pdp_reg_multi_group #(.NUM_GROUPS(NG), .CNT_W(2)) dut_b (
    .nvdla_core_clk(clk), .nvdla_core_rst(rst), .reg_offset(reg_offset),
    .reg_wr_data(reg_wr_data), .reg_wr_en(reg_wr_en), .reg_rd_data(rd_b),
    .consumer(consumer), .status(status), .op_done(op_done),
    .producer(producer_b), .op_en(op_en_b));

  // kind 0: read data, 1: producer port, 2: op_en port; sel picks the instance
  typedef struct {
    int          kind;
    bit          sel;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  logic chk_req = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(negedge clk) begin
    if (chk_req) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL scoreboard_empty: check requested with no expectation queued");
      end else begin
        exp_t e;
        logic [31:0] got;
        e = exp_q.pop_front();
        case (e.kind)
          0:       got = e.sel ? rd_b : rd_a;
          1:       got = 32'(e.sel ? producer_b : producer_a);
          default: got = 32'(e.sel ? op_en_b : op_en_a);
        endcase
        n_cmp++;
        if (got !== e.exp) begin
          n_bad++;
          $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, got, e.exp);
        end else begin
          $display("ok   %s: 0x%08h", e.name, got);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [11:0] off, input logic [31:0] data, input logic done);
    reg_offset  = off;
    reg_wr_data = data;
    reg_wr_en   = 1'b1;
    op_done     = done;
    tick();
    reg_wr_en   = 1'b0;
    op_done     = 1'b0;
  endtask

  task automatic pulse_done();
    op_done = 1'b1;
    tick();
    op_done = 1'b0;
  endtask

  task automatic expect_val(input int kind, input bit sel, input logic [11:0] off,
                            input logic [31:0] exp, input string name);
    exp_t e;
    e.kind = kind;
    e.sel  = sel;
    e.exp  = exp;
    e.name = name;
    reg_offset = off;
    exp_q.push_back(e);
    chk_req = 1'b1;
    tick();
    chk_req = 1'b0;
  endtask

  task automatic rd(input logic [11:0] off, input logic [31:0] exp, input string name);
    expect_val(0, 1'b0, off, exp, name);
  endtask

  initial begin
    rst         = 1'b1;
    reg_offset  = '0;
    reg_wr_data = '0;
    reg_wr_en   = 1'b0;
    op_done     = 1'b0;
    consumer    = 2'd2;
    status      = 8'hE4;
    tick(); tick(); tick();
    rst = 1'b0;

    // reset state and read map
    rd(12'h000, 32'h0000_00E4, "rst_status");
    rd(12'h004, 32'h0002_0000, "rst_pointer");
    rd(12'h008, 32'h0, "rst_op_enable");
    rd(12'h00C, 32'h0, "rst_op_en_all");
    rd(12'h010, 32'h0, "rst_done_cnt_a");
    expect_val(0, 1'b1, 12'h010, 32'h0, "rst_done_cnt_b");
    rd(12'h014, 32'h0, "rst_unmapped");
    expect_val(1, 1'b0, 12'h000, 32'h0, "rst_producer_port");
    expect_val(2, 1'b0, 12'h000, 32'h0, "rst_op_en_port");

    // pointer wraps modulo NUM_GROUPS
    wr(12'h004, 32'h7, 1'b0);
    rd(12'h004, 32'h0002_0003, "ptr_wrap_read");
    expect_val(1, 1'b0, 12'h000, 32'h3, "ptr_wrap_port");

    // set op_en[1]; writing 0 has no effect
    wr(12'h004, 32'h1, 1'b0);
    wr(12'h008, 32'h1, 1'b0);
    rd(12'h008, 32'h1, "op_enable_read");
    rd(12'h00C, 32'h2, "op_en_all_after_set");
    expect_val(2, 1'b0, 12'h000, 32'h2, "op_en_port_after_set");
    wr(12'h008, 32'h0, 1'b0);
    rd(12'h00C, 32'h2, "op_en_write0_noeffect");

    // op_done on consumer 1 clears and counts
    consumer = 2'd1;
    pulse_done();
    expect_val(2, 1'b0, 12'h000, 32'h0, "op_done_clears");
    rd(12'h010, 32'h1, "done_cnt_one");
    rd(12'h008, 32'h0, "op_enable_after_done");

    // same-group set and op_done: set wins
    wr(12'h008, 32'h1, 1'b1);
    rd(12'h00C, 32'h2, "set_wins_same_group");
    rd(12'h010, 32'h2, "done_cnt_two");

    // different groups: both applied
    wr(12'h004, 32'h2, 1'b0);
    wr(12'h008, 32'h1, 1'b1);
    rd(12'h00C, 32'h4, "set_clear_diff_groups");
    rd(12'h004, 32'h0001_0002, "pointer_with_consumer1");

    // three more events: wide counter 6, narrow counter saturated at 3
    pulse_done(); pulse_done(); pulse_done();
    rd(12'h010, 32'h6, "done_cnt_six");
    expect_val(0, 1'b1, 12'h010, 32'h3, "done_cnt_saturate_b");
    rd(12'h00C, 32'h4, "op_done_on_clear_group");

    // clear coinciding with op_done leaves 1; plain clear gives 0
    wr(12'h010, 32'hFFFF_FFFF, 1'b1);
    rd(12'h010, 32'h1, "clear_with_done_a");
    expect_val(0, 1'b1, 12'h010, 32'h1, "clear_with_done_b");
    wr(12'h010, 32'h0, 1'b0);
    rd(12'h010, 32'h0, "clear_plain");

    // writes to unmapped and read-only offsets are ignored
    wr(12'h020, 32'hFFFF_FFFF, 1'b0);
    wr(12'h00C, 32'hFFFF_FFFF, 1'b0);
    wr(12'h000, 32'hFFFF_FFFF, 1'b0);
    rd(12'h020, 32'h0, "unmapped_read");
    rd(12'h004, 32'h0001_0002, "pointer_untouched");
    rd(12'h00C, 32'h4, "op_en_all_untouched");

    // status is reflected combinationally
    status = 8'h1B;
    rd(12'h000, 32'h0000_001B, "status_live");

    // reset mid-operation, with op_done held high on the reset edge
    wr(12'h004, 32'h3, 1'b0);
    wr(12'h008, 32'h1, 1'b0);
    pulse_done(); pulse_done();
    rd(12'h00C, 32'hC, "pre_reset_op_en");
    rst = 1'b1;
    op_done = 1'b1;
    tick();
    rst = 1'b0;
    op_done = 1'b0;
    expect_val(1, 1'b0, 12'h000, 32'h0, "reset_producer");
    expect_val(2, 1'b0, 12'h000, 32'h0, "reset_op_en");
    rd(12'h010, 32'h0, "reset_done_cnt_a");
    expect_val(0, 1'b1, 12'h010, 32'h0, "reset_done_cnt_b");
    rd(12'h004, 32'h0001_0000, "reset_pointer_read");

    // drain with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) tick();
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0 pending", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
